// File: rtl/isa_pkg.sv
// isa_pkg: class ISA definitions shared by the instruction encoder.
// Holds class codes, opcode constants, field bit positions and the
// combinational encode function that packs request fields into a 32-bit word
// and flags requests that have no legal encoding.
package isa_pkg;

  typedef enum logic [1:0] {
    CLS_DATA_IMM = 2'b00,
    CLS_DATA_REG = 2'b01,
    CLS_LDST     = 2'b10,
    CLS_SYS      = 2'b11
  } cls_e;

  // Data opcodes (classes 00/01)
  localparam logic [4:0] OP_MOV  = 5'b00000;
  localparam logic [4:0] OP_MOVT = 5'b00001;
  localparam logic [4:0] OP_CLR  = 5'b00010;
  localparam logic [4:0] OP_SET  = 5'b00011;
  localparam logic [4:0] OP_LSL  = 5'b00100;
  localparam logic [4:0] OP_LSR  = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b10001;
  localparam logic [4:0] OP_SUB  = 5'b10010;
  localparam logic [4:0] OP_AND  = 5'b10011;
  localparam logic [4:0] OP_OR   = 5'b10100;
  localparam logic [4:0] OP_XOR  = 5'b10101;
  localparam logic [4:0] OP_NOT  = 5'b10110;
  localparam logic [4:0] OP_ADDS = 5'b11001;
  localparam logic [4:0] OP_SUBS = 5'b11010;
  localparam logic [4:0] OP_ANDS = 5'b11011;
  localparam logic [4:0] OP_ORS  = 5'b11100;
  localparam logic [4:0] OP_XORS = 5'b11101;

  // System/branch opcodes (class 11)
  localparam logic [4:0] OP_B     = 5'b00000;
  localparam logic [4:0] OP_BCOND = 5'b00001;
  localparam logic [4:0] OP_BR    = 5'b00010;
  localparam logic [4:0] OP_NOP   = 5'b00100;
  localparam logic [4:0] OP_HALT  = 5'b01000;

  // Field LSB positions within the instruction word
  localparam int unsigned CLS_LSB  = 30;
  localparam int unsigned OPC_LSB  = 25;
  localparam int unsigned DEST_LSB = 22;
  localparam int unsigned OP1_LSB  = 19;
  localparam int unsigned OP2_LSB  = 16;
  localparam int unsigned COND_LSB = 21;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(
    input logic [1:0]  cls,
    input logic [4:0]  opc,
    input logic [2:0]  dest,
    input logic [2:0]  op1,
    input logic [2:0]  op2,
    input logic [3:0]  cond,
    input logic [15:0] imm
  );
    enc_t r;
    r.legal = 1'b0;
    r.word  = '0;
    r.word[CLS_LSB +: 2] = cls;
    case (cls)
      CLS_DATA_IMM: begin
        r.legal = opc inside {[OP_MOV:OP_LSR], [OP_ADD:OP_XOR], [OP_ADDS:OP_XORS]};
        r.word[OPC_LSB +: 5]  = opc;
        r.word[DEST_LSB +: 3] = dest;
        r.word[OP1_LSB +: 3]  = op1;
        r.word[15:0]          = imm;
      end
      CLS_DATA_REG: begin
        r.legal = opc inside {[OP_ADD:OP_NOT], [OP_ADDS:OP_XORS]};
        r.word[OPC_LSB +: 5]  = opc;
        r.word[DEST_LSB +: 3] = dest;
        r.word[OP1_LSB +: 3]  = op1;
        // NOT is unary: operand-2 slot stays zero
        if (opc != OP_NOT) r.word[OP2_LSB +: 3] = op2;
      end
      CLS_LDST: begin
        r.legal = (opc[4:1] == 4'b0000);
        r.word[OPC_LSB]       = opc[0];
        r.word[DEST_LSB +: 3] = dest;
        r.word[OP1_LSB +: 3]  = op1;
        r.word[15:0]          = imm;
      end
      default: begin
        r.legal = !opc[4] && (opc inside {OP_B, OP_BCOND, OP_BR, OP_NOP, OP_HALT});
        r.word[OPC_LSB +: 4] = opc[3:0];
        case (opc)
          OP_B:     r.word[15:0] = imm;
          OP_BCOND: begin
            r.word[COND_LSB +: 4] = cond;
            r.word[15:0]          = imm;
          end
          OP_BR:    r.word[OP1_LSB +: 3] = op1;
          default:  ;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH x WIDTH synchronous FIFO, asynchronous active-high reset.
// Ports: clk, rst; push/wdata write side (ignored when full);
// pop/rdata read side (rdata is the head entry, 0 when empty);
// full, empty flags; one_left is high when exactly one entry is held.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             push_ok, pop_ok;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign one_left = (cnt == (PTR_W+1)'(1));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign rdata    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction requests into 32-bit ISA words,
// buffers them in a FIFO and streams them to instruction memory at an
// auto-incrementing word address.
// Ports: clk, rst (async, active-high); in_valid/in_ready request handshake with
// in_class, in_opcode, in_dest, in_op1, in_op2, in_cond, in_imm fields;
// addr_load/addr_base reload the write address; mem_we/mem_ready/mem_addr/
// mem_wdata memory write port; err_illegal pulse and saturating err_count for
// illegal requests; done pulses once a HALT word has been written.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_dest,
  input  logic [2:0]        in_op1,
  input  logic [2:0]        in_op2,
  input  logic [3:0]        in_cond,
  input  logic [15:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_illegal,
  output logic [7:0]        err_count,
  output logic              done
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e state;
  enc_t   enc;
  logic   accept, push, pop, full, empty, one_left, is_halt;

  assign enc      = encode(in_class, in_opcode, in_dest, in_op1, in_op2, in_cond, in_imm);
  assign in_ready = (state == RUN) && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc.legal;
  assign mem_we   = !empty;
  assign pop      = mem_we && mem_ready;
  assign is_halt  = (in_class == CLS_SYS) && (in_opcode == OP_HALT);

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (enc.word),
    .pop      (pop),
    .rdata    (mem_wdata),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      mem_addr    <= '0;
      err_illegal <= 1'b0;
      err_count   <= '0;
      done        <= 1'b0;
    end else begin
      err_illegal <= accept && !enc.legal;
      if (err_illegal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      if (addr_load)  mem_addr <= addr_base;
      else if (pop)   mem_addr <= mem_addr + ADDR_W'(1);

      done <= 1'b0;
      case (state)
        RUN:   if (push && is_halt) state <= DRAIN;
        // No pushes happen in DRAIN, so the HALT is the last queued entry.
        DRAIN: if (pop && one_left) begin
          done  <= 1'b1;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
